// File: rtl/se_cla_acc_if.sv
// Stream interface for the sign-extending accumulator: an input beat channel,
// a result channel and the frame-open status flag.
interface se_cla_acc_if #(
    parameter int A_W = 27,
    parameter int S_W = 51
) ();
    logic                  mode;
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_first;
    logic                  in_last;
    logic signed [A_W-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [S_W-1:0] out_data;
    logic                  out_ovf;
    logic                  busy;

    modport master (
        output mode, in_valid, in_first, in_last, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, busy
    );

    modport slave (
        input  mode, in_valid, in_first, in_last, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf, busy
    );
endinterface

// File: rtl/se_cla_acc.sv
// Sign-extending accumulator for the DCIM macro output path. Each accepted
// signed beat is widened to S_W+2 bits and either summed (mode 0) or
// shift-added MSB-first with a negative weight on the first beat (mode 1).
// The result of a frame is held on the output until the consumer takes it.
module se_cla_acc #(
    parameter int A_W = 27,
    parameter int S_W = 51,
    parameter bit SAT = 1'b0
) (
    input logic         clk,
    input logic         rst_n,
    se_cla_acc_if.slave bus
);
    // Two guard bits above S_W make 2*acc + x exact before range checking.
    localparam int X_W = S_W + 2;
    localparam logic signed [X_W-1:0] MAX_V = {3'b000, {(S_W-1){1'b1}}};
    localparam logic signed [X_W-1:0] MIN_V = {3'b111, {(S_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                state_p1, state_p0;
    logic signed [S_W-1:0] acc_p1, acc_p0;
    logic                  ovf_p1, ovf_p0;
    logic                  mode_p1, mode_p0;
    logic                  vld_p1;

    logic                  accept;
    logic                  start;
    logic                  mode_eff;
    logic signed [X_W-1:0] x;
    logic signed [X_W-1:0] prev;
    logic signed [X_W-1:0] nxt;
    logic                  step_ovf;

    function automatic logic out_of_range(input logic signed [X_W-1:0] v);
        return (v > MAX_V) || (v < MIN_V);
    endfunction

    // Clamp to the S_W signed range when saturating, otherwise wrap.
    function automatic logic signed [S_W-1:0] sat_wrap(input logic signed [X_W-1:0] v);
        if (SAT && (v > MAX_V))      return MAX_V[S_W-1:0];
        else if (SAT && (v < MIN_V)) return MIN_V[S_W-1:0];
        else                         return v[S_W-1:0];
    endfunction

    assign vld_p1        = (state_p1 == HOLD);
    assign bus.in_ready  = !(vld_p1 && !bus.out_ready);
    assign bus.out_valid = vld_p1;
    assign bus.out_data  = acc_p1;
    assign bus.out_ovf   = ovf_p1;
    assign bus.busy      = (state_p1 == ACCUM);

    assign accept   = bus.in_valid && bus.in_ready;
    assign start    = accept && (bus.in_first || (state_p1 != ACCUM));
    assign mode_eff = start ? bus.mode : mode_p1;

    // Widen the addend and the previous sum, then form the next partial sum.
    always_comb begin
        x        = {{(X_W-A_W){bus.in_data[A_W-1]}}, bus.in_data};
        prev     = start ? '0 : {{2{acc_p1[S_W-1]}}, acc_p1};
        nxt      = mode_eff ? ((prev <<< 1) + (start ? -x : x)) : (prev + x);
        step_ovf = out_of_range(nxt);
    end

    // Next-state: accepted beats update the sum; HOLD drains on out_ready.
    always_comb begin
        state_p0 = state_p1;
        acc_p0   = acc_p1;
        ovf_p0   = ovf_p1;
        mode_p0  = mode_p1;
        if (accept) begin
            acc_p0   = sat_wrap(nxt);
            ovf_p0   = start ? step_ovf : (ovf_p1 | step_ovf);
            mode_p0  = mode_eff;
            state_p0 = bus.in_last ? HOLD : ACCUM;
        end else if ((state_p1 == HOLD) && bus.out_ready) begin
            state_p0 = IDLE;
        end
    end

    // Stage p0 -> p1: frame state, sum, sticky overflow and latched mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1 <= IDLE;
            acc_p1   <= '0;
            ovf_p1   <= 1'b0;
            mode_p1  <= 1'b0;
        end else begin
            state_p1 <= state_p0;
            acc_p1   <= acc_p0;
            ovf_p1   <= ovf_p0;
            mode_p1  <= mode_p0;
        end
    end
endmodule

// File: tb/tb_se_cla_acc.sv
// Bench for se_cla_acc: directed frames plus randomized frames against a
// behavioural model, with a queue-based scoreboard on the result channel.
module tb_se_cla_acc;
    localparam int A_W = 27;
    localparam int S_W = 51;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    se_cla_acc_if #(.A_W(A_W), .S_W(S_W)) bus ();
    se_cla_acc #(.A_W(A_W), .S_W(S_W), .SAT(1'b0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    se_cla_acc_if #(.A_W(8), .S_W(10)) sbs ();
    se_cla_acc_if #(.A_W(8), .S_W(10)) sbw ();
    se_cla_acc #(.A_W(8), .S_W(10), .SAT(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(sbs));
    se_cla_acc #(.A_W(8), .S_W(10), .SAT(1'b0)) dut_w (.clk(clk), .rst_n(rst_n), .bus(sbw));

    int n_vec = 0;
    int n_err = 0;

    longint exp_d[$];
    bit     exp_o[$];

    longint m_acc;
    bit     m_ovf, m_mode, m_open;
    bit     rand_rdy = 1'b0;

    logic                  held = 1'b0;
    logic signed [S_W-1:0] held_d;
    logic                  held_o;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint wrapv(input longint v, input int sw);
        longint m, h, r;
        m = longint'(1) <<< sw;
        h = m >>> 1;
        r = (v + h) % m;
        if (r < 0) r += m;
        return r - h;
    endfunction

    // One accepted beat of the reference arithmetic at width sw.
    task automatic mstep(inout longint acc, inout bit ovf, inout bit md_l,
                         input bit start, input longint d, input bit md,
                         input int sw, input bit sat);
        longint hi, lo, prev, nxt;
        hi = (longint'(1) <<< (sw - 1)) - 1;
        lo = -(longint'(1) <<< (sw - 1));
        if (start) begin
            md_l = md;
            ovf  = 1'b0;
            prev = 0;
        end else begin
            prev = acc;
        end
        if (md_l) nxt = 2 * prev + (start ? -d : d);
        else      nxt = prev + d;
        if (nxt > hi || nxt < lo) ovf = 1'b1;
        if (sat && nxt > hi)      acc = hi;
        else if (sat && nxt < lo) acc = lo;
        else                      acc = wrapv(nxt, sw);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_beat(input longint d, input bit first, input bit last, input bit md);
        bit ok;
        bit st;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d[A_W-1:0];
        bus.in_first = first;
        bus.in_last  = last;
        bus.mode     = md;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                st = first || !m_open;
                mstep(m_acc, m_ovf, m_mode, st, d, md, S_W, 1'b0);
                m_open = !last;
                if (last) begin
                    exp_d.push_back(m_acc);
                    exp_o.push_back(m_ovf);
                end
                ok = 1'b1;
                cyc();
                break;
            end
            cyc();
        end
        if (!ok) chk("beat_accept_timeout", 0, 1);
        bus.in_valid = 1'b0;
        bus.in_data  = A_W'($urandom);
        bus.in_first = 1'($urandom);
        bus.in_last  = 1'($urandom);
    endtask

    function automatic longint rnd_data(input int w);
        logic [63:0] raw;
        longint hi;
        int sel;
        hi  = (longint'(1) <<< (w - 1)) - 1;
        sel = $urandom_range(0, 3);
        raw = {$urandom, $urandom};
        if (sel == 0) return hi;
        if (sel == 1) return -hi - 1;
        return wrapv(longint'(raw), w);
    endfunction

    // Small-width pair: same beat to the saturating and the wrapping instance.
    longint sa_acc, sw_acc;
    bit     sa_ovf, sw_ovf, sa_md, sw_md;

    task automatic small_beat(input longint d, input bit first, input bit last, input bit md);
        sbs.in_valid = 1'b1; sbw.in_valid = 1'b1;
        sbs.in_data  = d[7:0]; sbw.in_data = d[7:0];
        sbs.in_first = first;  sbw.in_first = first;
        sbs.in_last  = last;   sbw.in_last  = last;
        sbs.mode     = md;     sbw.mode     = md;
        mstep(sa_acc, sa_ovf, sa_md, first, d, md, 10, 1'b1);
        mstep(sw_acc, sw_ovf, sw_md, first, d, md, 10, 1'b0);
        cyc();
        sbs.in_valid = 1'b0; sbw.in_valid = 1'b0;
    endtask

    task automatic small_check(input string tag);
        chk({tag, "_sat_vld"}, sbs.out_valid, 1);
        chk({tag, "_sat_data"}, sbs.out_data, sa_acc);
        chk({tag, "_sat_ovf"}, sbs.out_ovf, sa_ovf);
        chk({tag, "_wrap_vld"}, sbw.out_valid, 1);
        chk({tag, "_wrap_data"}, sbw.out_data, sw_acc);
        chk({tag, "_wrap_ovf"}, sbw.out_ovf, sw_ovf);
    endtask

    // Result-channel monitor: stability under backpressure and scoreboard pop.
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held && bus.out_valid) begin
                chk("hold_data", bus.out_data, held_d);
                chk("hold_ovf", bus.out_ovf, held_o);
            end
            held   = bus.out_valid && !bus.out_ready;
            held_d = bus.out_data;
            held_o = bus.out_ovf;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_d.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    longint e;
                    logic [S_W-1:0] es;
                    e  = exp_d.pop_front();
                    es = e[S_W-1:0];
                    chk("result_data", bus.out_data, $signed(es));
                    chk("result_ovf", bus.out_ovf, exp_o.pop_front());
                end
            end
        end
    end

    initial begin
        bus.mode = 1'b0; bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
        bus.in_data = '0; bus.out_ready = 1'b1;
        sbs.mode = 1'b0; sbs.in_valid = 1'b0; sbs.in_first = 1'b0; sbs.in_last = 1'b0;
        sbs.in_data = '0; sbs.out_ready = 1'b1;
        sbw.mode = 1'b0; sbw.in_valid = 1'b0; sbw.in_first = 1'b0; sbw.in_last = 1'b0;
        sbw.in_data = '0; sbw.out_ready = 1'b1;
        m_acc = 0; m_ovf = 0; m_mode = 0; m_open = 0;
        sa_acc = 0; sw_acc = 0; sa_ovf = 0; sw_ovf = 0; sa_md = 0; sw_md = 0;

        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_ovf", bus.out_ovf, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Plain sum with exact one-cycle result latency.
        send_beat(5, 1, 0, 0);
        send_beat(-3, 0, 0, 0);
        chk("t1_pre_valid", bus.out_valid, 0);
        chk("t1_busy", bus.busy, 1);
        send_beat(7, 0, 1, 0);
        chk("t1_valid", bus.out_valid, 1);
        chk("t1_data", bus.out_data, 9);
        chk("t1_ovf", bus.out_ovf, 0);

        // Shift-add with negative first-beat weight.
        send_beat(3, 1, 0, 1);
        send_beat(0, 0, 0, 0);
        send_beat(3, 0, 1, 0);
        chk("t2_data", bus.out_data, -9);

        // Backpressure: result held, input stalled, then both move together.
        cyc();
        bus.out_ready = 1'b0;
        send_beat(4, 1, 1, 0);
        bus.in_valid = 1'b1; bus.in_data = 11; bus.in_first = 1'b1; bus.in_last = 1'b1;
        bus.mode = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_in_ready", bus.in_ready, 0);
            chk("t4_hold_data", bus.out_data, 4);
            cyc();
        end
        bus.out_ready = 1'b1;
        send_beat(11, 1, 1, 0);
        chk("t4_new_valid", bus.out_valid, 1);
        chk("t4_new_data", bus.out_data, 11);
        cyc();

        // Reset in the middle of an open frame.
        send_beat(100, 1, 0, 0);
        send_beat(100, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("t5_valid", bus.out_valid, 0);
        chk("t5_data", bus.out_data, 0);
        chk("t5_ovf", bus.out_ovf, 0);
        chk("t5_busy", bus.busy, 0);
        m_open = 1'b0;
        cyc();
        rst_n = 1'b1;
        send_beat(4, 1, 1, 0);
        chk("t5_next_data", bus.out_data, 4);

        // Most negative addend, both modes.
        send_beat(-(longint'(1) <<< 26), 1, 1, 0);
        chk("t6_m0_data", bus.out_data, -67108864);
        chk("t6_m0_ovf", bus.out_ovf, 0);
        send_beat(-(longint'(1) <<< 26), 1, 1, 1);
        chk("t6_m1_data", bus.out_data, 67108864);
        chk("t6_m1_ovf", bus.out_ovf, 0);

        // Narrow instances: saturation versus wrap.
        for (int i = 0; i < 5; i++) small_beat(127, i == 0, i == 4, 1'b0);
        chk("t3_sat_data", sbs.out_data, 511);
        chk("t3_sat_ovf", sbs.out_ovf, 1);
        chk("t3_wrap_data", sbw.out_data, -389);
        chk("t3_wrap_ovf", sbw.out_ovf, 1);
        small_check("t3_model");
        for (int f = 0; f < 20; f++) begin
            int len;
            bit md;
            len = $urandom_range(1, 8);
            md  = 1'($urandom);
            for (int i = 0; i < len; i++)
                small_beat(rnd_data(8), i == 0, i == len - 1, (i == 0) ? md : 1'($urandom));
            small_check("small_rand");
        end

        // Randomized frames with random backpressure, gaps and restarts.
        rand_rdy = 1'b1;
        for (int f = 0; f < 60; f++) begin
            int len;
            bit md;
            md  = 1'($urandom);
            len = $urandom_range(1, md ? 30 : 8);
            for (int i = 0; i < len; i++) begin
                bit fst;
                fst = (i == 0) || ($urandom_range(0, 15) == 0);
                send_beat(rnd_data(A_W), fst, i == len - 1, fst ? md : 1'($urandom));
                for (int g = $urandom_range(0, 2); g > 0; g--) cyc();
            end
        end
        rand_rdy = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_d.size() != 0; k++) cyc();
        chk("scoreboard_drained", exp_d.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
